// File: rtl/demux_pkg.sv
// Shared types and constants for the 8-bit 1-to-2 demultiplexer.
// Optional feature macro: DEMUX_CNT_EN (per-channel delivered-word counters).
package demux_pkg;

    localparam int DEMUX_WIDTH_DEF = 8;
    localparam int DEMUX_CNT_WIDTH = 8;

    // One-entry slot occupancy.
    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    // Channel select encoding for S.
    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;

endpackage

// File: rtl/demux_slot.sv
// One-entry valid/ready output register for a single demux channel.
// Handshake: a word moves out when valid & ready are both 1 at a rising
// edge; a load in the same cycle replaces the word without a bubble.
// Optional feature macro: DEMUX_CNT_EN adds a wrapping drain counter.
module demux_slot
    import demux_pkg::*;
#(
    parameter int WIDTH = DEMUX_WIDTH_DEF
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_data,
    input  logic              ready,
    output logic [WIDTH-1:0]  data,
    output slot_state_e       state
`ifdef DEMUX_CNT_EN
    ,
    output logic [DEMUX_CNT_WIDTH-1:0] cnt
`endif
);

    slot_state_e         state_q, state_d;
    logic [WIDTH-1:0]    data_q, data_d;
    logic                drain;

`ifdef DEMUX_CNT_EN
    logic [DEMUX_CNT_WIDTH-1:0] cnt_q, cnt_d;
`endif

    // State register: slot occupancy, held word and optional counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SLOT_EMPTY;
            data_q  <= '0;
`ifdef DEMUX_CNT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
`ifdef DEMUX_CNT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    // Next state: load wins over drain, so drain+load keeps the slot full.
    always_comb begin
        drain   = (state_q == SLOT_FULL) && ready;
        state_d = state_q;
        data_d  = data_q;
        if (load) begin
            state_d = SLOT_FULL;
            data_d  = load_data;
        end else if (drain) begin
            state_d = SLOT_EMPTY;
        end
`ifdef DEMUX_CNT_EN
        cnt_d = drain ? cnt_q + 1'b1 : cnt_q;
`endif
    end

    // Outputs come straight from registers; the last word stays after a drain.
    always_comb begin
        state = state_q;
        data  = data_q;
`ifdef DEMUX_CNT_EN
        cnt   = cnt_q;
`endif
    end

endmodule

// File: rtl/demux_8bit_1para2.sv
// Registered 1-to-2 demultiplexer with valid/ready handshaking.
// Handshake: a transfer happens on any rising edge where valid & ready are
// both 1; in_ready depends combinationally on S and the selected channel's
// ready, never on in_valid.
// Optional feature macro: DEMUX_CNT_EN exposes cnt0/cnt1 drain counters.
module demux_8bit_1para2
    import demux_pkg::*;
#(
    parameter int WIDTH = DEMUX_WIDTH_DEF
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] D,
    input  logic             S,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] Y0,
    output logic             y0_valid,
    input  logic             y0_ready,
    output logic [WIDTH-1:0] Y1,
    output logic             y1_valid,
    input  logic             y1_ready
`ifdef DEMUX_CNT_EN
    ,
    output logic [DEMUX_CNT_WIDTH-1:0] cnt0,
    output logic [DEMUX_CNT_WIDTH-1:0] cnt1
`endif
);

    slot_state_e s0_state, s1_state;
    logic        accept;
    logic        load0, load1;

    // Select decode: the selected slot must be empty or draining this cycle.
    always_comb begin
        y0_valid = (s0_state == SLOT_FULL);
        y1_valid = (s1_state == SLOT_FULL);
        in_ready = (S == CH1) ? (!y1_valid || y1_ready) : (!y0_valid || y0_ready);
        accept   = in_valid && in_ready;
        load0    = accept && (S == CH0);
        load1    = accept && (S == CH1);
    end

    demux_slot #(.WIDTH(WIDTH)) s0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load0),
        .load_data (D),
        .ready     (y0_ready),
        .data      (Y0),
        .state     (s0_state)
`ifdef DEMUX_CNT_EN
        ,
        .cnt       (cnt0)
`endif
    );

    demux_slot #(.WIDTH(WIDTH)) s1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load1),
        .load_data (D),
        .ready     (y1_ready),
        .data      (Y1),
        .state     (s1_state)
`ifdef DEMUX_CNT_EN
        ,
        .cnt       (cnt1)
`endif
    );

endmodule
